store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 st_valid  input  1  pipeline store request valid.
REQ-004 st_ready  output  1  unit can accept a store this cycle.
REQ-005 st_addr  input  32  byte address of store.
REQ-006 st_data  input  32  store data, right-justified.
REQ-007 st_funct3  input  3  store size: 3'b000 byte, 3'b001 half, 3'b010 word; others illegal.
REQ-008 mem_req  output  1  memory write request.
REQ-009 mem_gnt  input  1  memory accepts current beat.
REQ-010 mem_addr  output  32  word-aligned write address, bits[1:0] always 0.
REQ-011 mem_wdata  output  32  lane-positioned write data.
REQ-012 mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-013 st_err  output  1  one-cycle pulse: illegal st_funct3 accepted.
REQ-014 busy  output  1  a store is in flight (state not IDLE).

Function
REQ-015 FSM states SHALL be IDLE, BEAT0, BEAT1; st_ready=1 only in IDLE.
REQ-016 Accept = st_valid & st_ready; on accept, addr/data/funct3 SHALL be latched and the state SHALL leave IDLE next cycle.
REQ-017 Lane gen: off=addr[1:0]; mask byte=4'b0001, half=4'b0011, word=4'b1111; m8={4'b0,mask}<<off; d64={32'b0,data}<<(8*off).
REQ-018 Two beats SHALL be needed iff m8[7:4]!=0 (half at off 3, word at off 1..3); otherwise one beat.
REQ-019 BEAT0: mem_addr={addr[31:2],2'b00}, mem_wdata=d64[31:0], mem_be=m8[3:0].
REQ-020 BEAT1: mem_addr={addr[31:2],2'b00}+4 (mod 2^32, 0xFFFFFFFC wraps to 0x0), mem_wdata=d64[63:32], mem_be=m8[7:4].
REQ-021 Disabled lanes of mem_wdata SHALL be zero.
REQ-022 mem_req SHALL be 1 in BEAT0/BEAT1; addr/wdata/be SHALL stay stable until the mem_gnt cycle.
REQ-023 BEAT0 & mem_gnt -> BEAT1 if two beats, else IDLE; BEAT1 & mem_gnt -> IDLE.
REQ-024 Latency: accept in cycle N -> mem_req=1 in N+1; single-beat with mem_gnt=1 in N+1 -> st_ready=1 in N+2.
REQ-025 No back-to-back accept: new store accepted only when state is IDLE at clock edge.
REQ-026 Illegal st_funct3: accepted normally, st_err=1 in N+1 only, no mem_req, state returns to IDLE in N+1.
REQ-027 mem_gnt while mem_req=0 SHALL be ignored.
REQ-028 busy=1 exactly when state!=IDLE.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE regardless of state, abandoning any beat (incl. BEAT1 after BEAT0 granted).
REQ-030 Values after reset: st_ready=1, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, st_err=0, busy=0.
REQ-031 st_valid during reset SHALL NOT be accepted.

Structure
REQ-032 Shared package SHALL hold funct3 size constants (SB/SH/SW), lane masks, and the state enum.
REQ-033 Combinational lane generator SHALL be sub-module store_lane_gen (addr[1:0], funct3, data -> d64, m8, two_beat, illegal).
REQ-034 Latched request and FSM state SHALL be the only sequential storage.

Verification
REQ-035 sb addr 0x1002 data 0xAB, gnt=1 -> one beat: addr 0x1000, be 4'b0100, wdata 0x00AB0000.
REQ-036 sw addr 0x2001 data 0x11223344, gnt=1 -> beat0 0x2000/be 1110/wdata 0x22334400; beat1 0x2004/be 0001/wdata 0x00000011.
REQ-037 sh addr 0x3003 data 0xBEEF, gnt low 3 cycles -> beat0 held stable 4 cycles (0x3000/be 1000/0xEF000000), then 0x3004/be 0001/0x000000BE.
REQ-038 sw addr 0xFFFFFFFE data 0xCAFEF00D -> beat1 addr 0x00000000, be 0011, wdata 0x0000CAFE.
REQ-039 st_funct3=3'b011 -> st_err pulse one cycle, no mem_req, st_ready=1 next cycle.
REQ-040 reset asserted in BEAT1 -> next cycle mem_req=0, busy=0, st_ready=1.

Source files
------------

// File: rtl/store_align_unit_pkg.sv
// Shared store-size codes, lane masks and FSM states.
// Imported by store_lane_gen and store_align_unit.
package store_align_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: places store data and byte enables
// over two word beats. In: off_i, funct3_i, data_i. Out: d64_o, m8_o,
// two_beat_o, illegal_o.
module store_lane_gen
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [63:0] d64_o,
  output logic [7:0]  m8_o,
  output logic        two_beat_o,
  output logic        illegal_o
);

  logic [3:0]  mask;
  logic [31:0] dmask;

  always_comb begin
    mask      = 4'b0000;
    illegal_o = 1'b0;
    unique case (1'b1)
      (funct3_i == F3_SB): mask = MASK_B;
      (funct3_i == F3_SH): mask = MASK_H;
      (funct3_i == F3_SW): mask = MASK_W;
      default:             illegal_o = 1'b1;
    endcase
  end

  // Bits above the store size are cleared so disabled lanes stay zero.
  assign dmask = {{8{mask[3]}}, {8{mask[2]}},
                  {8{mask[1]}}, {8{mask[0]}}};

  assign d64_o = {32'b0, data_i & dmask} << {off_i, 3'b000};
  assign m8_o  = {4'b0000, mask} << off_i;

  assign two_beat_o = |m8_o[7:4];

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a store, splits it into one or two
// aligned write beats. Ports: st_* request side, mem_* write side,
// st_err illegal-size pulse, busy while a store is in flight.
module store_align_unit
  import store_align_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;

  logic [63:0] d64;
  logic [7:0]  m8;
  logic        two_beat;
  logic        illegal;
  logic [31:0] base;

  store_lane_gen u_lane (
    .off_i      (addr_q[1:0]),
    .funct3_i   (f3_q),
    .data_i     (data_q),
    .d64_o      (d64),
    .m8_o       (m8),
    .two_beat_o (two_beat),
    .illegal_o  (illegal)
  );

  assign base = {addr_q[31:2], 2'b00};
  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    f3_d      = f3_q;
    st_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    st_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          addr_d  = st_addr;
          data_d  = st_data;
          f3_d    = st_funct3;
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: begin
        // Illegal size: flag it, never touch memory.
        if (illegal) begin
          st_err  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_req   = 1'b1;
          mem_addr  = base;
          mem_wdata = d64[31:0];
          mem_be    = m8[3:0];
          if (mem_gnt)
            state_d = two_beat ? S_BEAT1 : S_IDLE;
        end
      end
      S_BEAT1: begin
        mem_req   = 1'b1;
        mem_addr  = base + 32'd4;
        mem_wdata = d64[63:32];
        mem_be    = m8[7:4];
        if (mem_gnt)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: expected write beats are
// queued at issue time and checked by an independent monitor.
module tb_store_align_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_err;
  logic        busy;

  int checks;
  int failures;
  int err_exp;
  beat_t q[$];

  store_align_unit dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .st_err    (st_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  b);
    beat_t e;
    e.addr  = a;
    e.wdata = d;
    e.be    = b;
    q.push_back(e);
  endtask

  // Drive one request at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [2:0]  f);
    int n;
    n = 0;
    @(negedge clk);
    while (!st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: st_ready stuck low");
    end
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  // Monitor: front beat must be presented unchanged every
  // cycle mem_req is high; it retires on the grant cycle.
  always @(negedge clk) begin
    if (!reset && mem_req) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexp_req: addr 0x%08h with empty queue",
                 mem_addr);
      end else begin
        chk("beat_addr", mem_addr, q[0].addr);
        chk("beat_wdata", mem_wdata, q[0].wdata);
        chk("beat_be", {28'h0, mem_be}, {28'h0, q[0].be});
        if (mem_gnt) void'(q.pop_front());
      end
    end
    if (!reset && st_err) begin
      checks++;
      if (err_exp > 0) err_exp--;
      else begin
        failures++;
        $display("FAIL unexp_err: st_err got 1 expected 0");
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q", q.size(), 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    err_exp   = 0;
    reset     = 1'b1;
    st_valid  = 1'b1;
    st_addr   = 32'h1234_5678;
    st_data   = 32'hFFFF_FFFF;
    st_funct3 = 3'b010;
    mem_gnt   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    st_valid = 1'b0;

    @(negedge clk);
    chk("rst_ready", st_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", st_err, 0);
    chk("rst_busy", busy, 0);

    // sb single beat with latency checks
    push(32'h1000, 32'h00AB_0000, 4'b0100);
    issue(32'h1002, 32'h0000_00AB, 3'b000);
    @(negedge clk);
    chk("lat_req", mem_req, 1);
    @(negedge clk);
    chk("lat_ready", st_ready, 1);
    chk("lat_busy", busy, 0);

    // sw offset 1
    push(32'h2000, 32'h2233_4400, 4'b1110);
    push(32'h2004, 32'h0000_0011, 4'b0001);
    issue(32'h2001, 32'h1122_3344, 3'b010);
    drain();

    // sh offset 3, grant withheld 3 cycles
    mem_gnt = 1'b0;
    push(32'h3000, 32'hEF00_0000, 4'b1000);
    push(32'h3004, 32'h0000_00BE, 4'b0001);
    issue(32'h3003, 32'h0000_BEEF, 3'b001);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", q.size(), 2);
    mem_gnt = 1'b1;
    drain();

    // upper data bits must not leak into disabled lanes
    push(32'h4000, 32'h0000_5A00, 4'b0010);
    issue(32'h4001, 32'hFFFF_FF5A, 3'b000);
    push(32'h4000, 32'hABCD_0000, 4'b1100);
    issue(32'h4002, 32'h1234_ABCD, 3'b001);
    push(32'h4000, 32'hDEAD_BEEF, 4'b1111);
    issue(32'h4000, 32'hDEAD_BEEF, 3'b010);
    push(32'h6000, 32'h3344_0000, 4'b1100);
    push(32'h6004, 32'h0000_1122, 4'b0011);
    issue(32'h6002, 32'h1122_3344, 3'b010);
    push(32'h7000, 32'hDD00_0000, 4'b1000);
    push(32'h7004, 32'h00AA_BBCC, 4'b0111);
    issue(32'h7003, 32'hAABB_CCDD, 3'b010);
    drain();

    // address wrap on second beat
    push(32'hFFFF_FFFC, 32'hF00D_0000, 4'b1100);
    push(32'h0000_0000, 32'h0000_CAFE, 4'b0011);
    issue(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b010);
    drain();

    // illegal funct3
    err_exp = 1;
    issue(32'h8000, 32'h1111_1111, 3'b011);
    @(negedge clk);
    chk("ill_req", mem_req, 0);
    @(negedge clk);
    chk("ill_ready", st_ready, 1);
    chk("ill_err_seen", err_exp, 0);
    chk("ill_q", q.size(), 0);

    // reset while in BEAT1
    mem_gnt = 1'b0;
    push(32'h5000, 32'h2233_4400, 4'b1110);
    push(32'h5004, 32'h0000_0011, 4'b0001);
    issue(32'h5001, 32'h1122_3344, 3'b010);
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("b1_busy", busy, 1);
    chk("b1_addr", mem_addr, 32'h5004);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_b1_req", mem_req, 0);
    chk("rst_b1_busy", busy, 0);
    chk("rst_b1_ready", st_ready, 1);
    chk("rst_b1_be", mem_be, 0);
    chk("rst_b1_left", q.size(), 1);
    q.delete();
    mem_gnt = 1'b1;

    // unit usable after reset
    push(32'h9000, 32'h0000_0077, 4'b0001);
    issue(32'h9000, 32'h0000_0077, 3'b000);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
